// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues in-order requests
// to instruction memory under a credit limit, tracks in-flight requests in an
// address queue, buffers returned words with their PCs and hands them to
// decode over a valid/ready interface. A redirect restarts fetch at a new PC,
// flushes the buffer and arranges for stale in-flight responses to be dropped.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    // Pointer width indexes DEPTH entries; counters must also hold DEPTH itself.
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    // Architectural state
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_outstanding;   // granted requests whose response has not returned
    logic [CNT_W-1:0] r_drop;          // responses still to be discarded after a redirect

    // In-order address queue: one entry per granted request
    logic [31:0]      r_aq_addr [DEPTH];
    logic [PTR_W-1:0] r_aq_wptr;
    logic [PTR_W-1:0] r_aq_rptr;

    // Instruction buffer toward decode
    logic [31:0]      r_buf_instr [DEPTH];
    logic [31:0]      r_buf_pc    [DEPTH];
    logic [PTR_W-1:0] r_buf_wptr;
    logic [PTR_W-1:0] r_buf_rptr;
    logic [CNT_W-1:0] r_count;

    // Last head presented to decode, held while the buffer is empty
    logic [31:0]      r_last_instr;
    logic [31:0]      r_last_pc;

    // Combinational control
    logic [CNT_W:0]   w_inflight;
    logic             w_req;
    logic             w_issue;
    logic             w_resp;
    logic             w_valid;
    logic             w_keep;
    logic             w_pop;
    logic [31:0]      w_redirect_target;
    logic [31:0]      w_aq_head;

    // Credit covers both requests in flight (including ones to be dropped) and
    // words already buffered, so a returning response always has a free slot.
    assign w_inflight        = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req             = !rst && !redirect_valid && (w_inflight < CREDIT_LIMIT);
    assign w_issue           = w_req && imem_gnt;
    assign w_resp            = imem_rvalid;
    assign w_valid           = (r_count != '0);
    assign w_keep            = w_resp && !redirect_valid && (r_drop == '0);
    assign w_pop             = w_valid && id_ready && !redirect_valid;
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_aq_head         = r_aq_addr[r_aq_rptr];

    // PC: jump on redirect, otherwise advance by one word per issued request
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_issue) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Outstanding-request and pending-drop counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            // Issue and response in the same cycle cancel out.
            case ({w_issue, w_resp})
                2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase

            // A redirect makes every older request stale; a response arriving
            // in the redirect cycle is discarded directly and not counted.
            if (redirect_valid) begin
                r_drop <= w_resp ? (r_outstanding - CNT_ONE) : r_outstanding;
            end else if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - CNT_ONE;
            end
        end
    end

    // Address queue pointers: push on issue, pop on every response (stale or not)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aq_wptr <= '0;
            r_aq_rptr <= '0;
        end else begin
            if (w_issue) begin
                r_aq_wptr <= r_aq_wptr + PTR_ONE;
            end
            if (w_resp) begin
                r_aq_rptr <= r_aq_rptr + PTR_ONE;
            end
        end
    end

    // Address queue storage
    // NOTE: queue and buffer storage is deliberately not reset; the pointers
    // and counts are, so no entry is ever read before it has been written.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_aq_addr[r_aq_wptr] <= r_pc;
        end
    end

    // Instruction buffer pointers and occupancy; a redirect empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_wptr <= '0;
            r_buf_rptr <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_buf_wptr <= '0;
            r_buf_rptr <= '0;
            r_count    <= '0;
        end else begin
            if (w_keep) begin
                r_buf_wptr <= r_buf_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_buf_rptr <= r_buf_rptr + PTR_ONE;
            end
            if (w_keep && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_keep && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Instruction buffer storage: returned word paired with its request PC
    always_ff @(posedge clk) begin
        if (w_keep) begin
            r_buf_instr[r_buf_wptr] <= imem_rdata;
            r_buf_pc[r_buf_wptr]    <= w_aq_head;
        end
    end

    // Remember the presented head so the decode outputs hold when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else if (w_valid) begin
            r_last_instr <= r_buf_instr[r_buf_rptr];
            r_last_pc    <= r_buf_pc[r_buf_rptr];
        end
    end

    // Output drive: memory request from credit, decode head read combinationally
    // NOTE: each output gets a default first so no path through this block
    // leaves a value unassigned and a latch is never inferred.
    always_comb begin
        imem_req  = w_req;
        imem_addr = r_pc;
        id_valid  = w_valid;
        id_instr  = r_last_instr;
        id_pc     = r_last_pc;
        if (w_valid) begin
            id_instr = r_buf_instr[r_buf_rptr];
            id_pc    = r_buf_pc[r_buf_rptr];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Two instances share the
// stimulus (selected by sel): A uses RESET_PC=0, DEPTH=2 and B uses
// RESET_PC=FFFF_FFF8, DEPTH=4. A bench memory model answers granted requests
// in order; words belonging to the current fetch stream are pushed to the
// scoreboard when the response is driven and compared when decode pops them.

module tb_fetch_unit;

    localparam logic [31:0] PC_A    = 32'h0000_0000;
    localparam logic [31:0] PC_B    = 32'hFFFF_FFF8;
    localparam int          DEPTH_A = 2;
    localparam int          DEPTH_B = 4;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        ready = 1'b0;

    logic        gnt_a, rvalid_a, redir_a, ready_a;
    logic        gnt_b, rvalid_b, redir_b, ready_b;
    logic        req_a, idv_a, req_b, idv_b;
    logic [31:0] addr_a, instr_a, pc_a, addr_b, instr_b, pc_b;
    logic        req, idv;
    logic [31:0] addr, instr, pcv;

    mreq_t       mem_q[$];
    exp_t        sb_q[$];
    logic [31:0] pop_log[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          first_valid = -1;
    int          n_valid = 0;
    int          n_issue = 0;
    int          resp_pct = 100;
    bit          resp_en = 1'b1;
    logic [31:0] exp_fetch = '0;

    always #5 clk = ~clk;

    assign gnt_a    = gnt && !sel;
    assign rvalid_a = rvalid && !sel;
    assign redir_a  = redir && !sel;
    assign ready_a  = ready && !sel;
    assign gnt_b    = gnt && sel;
    assign rvalid_b = rvalid && sel;
    assign redir_b  = redir && sel;
    assign ready_b  = ready && sel;

    assign req   = sel ? req_b   : req_a;
    assign idv   = sel ? idv_b   : idv_a;
    assign addr  = sel ? addr_b  : addr_a;
    assign instr = sel ? instr_b : instr_a;
    assign pcv   = sel ? pc_b    : pc_a;

    fetch_unit #(.RESET_PC(PC_A), .DEPTH(DEPTH_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .imem_req(req_a), .imem_addr(addr_a), .imem_gnt(gnt_a),
        .imem_rvalid(rvalid_a), .imem_rdata(rdata),
        .redirect_valid(redir_a), .redirect_pc(redir_pc),
        .id_valid(idv_a), .id_ready(ready_a), .id_instr(instr_a), .id_pc(pc_a)
    );

    fetch_unit #(.RESET_PC(PC_B), .DEPTH(DEPTH_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(gnt_b),
        .imem_rvalid(rvalid_b), .imem_rdata(rdata),
        .redirect_valid(redir_b), .redirect_pc(redir_pc),
        .id_valid(idv_b), .id_ready(ready_b), .id_instr(instr_b), .id_pc(pc_b)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] exp);
        if (idx < pop_log.size()) check(tag, pop_log[idx], exp);
        else check({tag, "_missing"}, 32'(pop_log.size()), 32'(idx + 1));
    endtask

    // One clock cycle: drive memory response, sample outputs, update model.
    // Called at a negedge; returns at the next negedge.
    task automatic step();
        logic        s_req, s_idv;
        logic [31:0] s_addr, s_pc, s_instr;
        int          dep;
        exp_t        e;
        mreq_t       m;
        dep = sel ? DEPTH_B : DEPTH_A;
        rvalid = 1'b0;
        if (resp_en && mem_q.size() > 0) begin
            if (mem_q[0].cyc < cyc && $urandom_range(99) < resp_pct) rvalid = 1'b1;
        end
        if (rvalid) rdata = word_of(mem_q[0].addr);
        else rdata = $urandom();
        #1;
        s_req = req; s_idv = idv; s_addr = addr; s_pc = pcv; s_instr = instr;
        check("imem_req", 32'(s_req), 32'(!redir && (mem_q.size() + sb_q.size() < dep)));
        check("id_valid", 32'(s_idv), 32'(sb_q.size() > 0));
        if (s_idv) n_valid++;
        if (s_idv && first_valid < 0) first_valid = cyc;
        if (s_idv && ready && !redir && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("id_pc", s_pc, e.pc);
            check("id_instr", s_instr, e.instr);
            pop_log.push_back(s_pc);
        end
        if (redir) begin
            epoch++;
            sb_q.delete();
            exp_fetch = redir_pc & 32'hFFFF_FFFC;
        end
        if (s_req && gnt) begin
            check("imem_addr", s_addr, exp_fetch);
            m.addr = exp_fetch; m.cyc = cyc; m.epoch = epoch;
            mem_q.push_back(m);
            exp_fetch = exp_fetch + 32'd4;
            n_issue++;
        end
        if (rvalid) begin
            m = mem_q.pop_front();
            if (m.epoch == epoch) begin
                e.pc = m.addr; e.instr = word_of(m.addr);
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        redir = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_outputs(input string tag, input logic [31:0] rpc);
        check({tag, "_req"}, 32'(req), 32'd0);
        check({tag, "_addr"}, addr, rpc);
        check({tag, "_id_valid"}, 32'(idv), 32'd0);
        check({tag, "_id_instr"}, instr, 32'd0);
        check({tag, "_id_pc"}, pcv, 32'd0);
    endtask

    task automatic do_reset(input logic s, input logic [31:0] rpc);
        sel = s; rst = 1'b1; gnt = 1'b0; ready = 1'b0; redir = 1'b0;
        rvalid = 1'b0; resp_en = 1'b1; resp_pct = 100;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset", rpc);
        mem_q.delete(); sb_q.delete(); pop_log.delete();
        cyc = 0; epoch = 0; exp_fetch = rpc; first_valid = -1; n_valid = 0; n_issue = 0;
        rst = 1'b0;
    endtask

    task automatic run_random(input int n, input int redir_pct);
        for (int i = 0; i < n; i++) begin
            gnt = ($urandom_range(99) < 75);
            ready = ($urandom_range(99) < 70);
            resp_pct = 65;
            if ($urandom_range(99) < redir_pct) begin
                redir = 1'b1;
                redir_pc = $urandom();
            end
            step();
        end
        resp_pct = 100;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        bit found;

        // ---- A: streaming from reset, 1-cycle memory ----
        do_reset(1'b0, PC_A);
        gnt = 1'b1; ready = 1'b1;
        run(16);
        check("a_first_valid_cycle", 32'(first_valid), 32'd2);
        check_log("a_stream0", 0, 32'h0);
        check_log("a_stream1", 1, 32'h4);
        check_log("a_stream2", 2, 32'h8);
        check_log("a_stream3", 3, 32'hC);

        // ---- A: decode stalls, buffer fills, then resumes in order ----
        do_reset(1'b0, PC_A);
        gnt = 1'b1; ready = 1'b0;
        run(10);
        check("a_stall_grants", 32'(n_issue), 32'(DEPTH_A));
        ready = 1'b1;
        run(12);
        check_log("a_resume0", 0, 32'h0);
        check_log("a_resume1", 1, 32'h4);
        check_log("a_resume2", 2, 32'h8);
        check_log("a_resume3", 3, 32'hC);

        // ---- A: redirect in the same cycle as rvalid and a pop ----
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() > 0 && mem_q[0].cyc < cyc && idv && ready) begin
                redir = 1'b1; redir_pc = 32'h0000_0203;
                pop_log.delete();
                step();
                found = 1'b1;
            end else begin
                step();
            end
        end
        check("a_same_cycle_redirect_reached", 32'(found), 32'd1);
        run(10);
        check_log("a_after_redirect0", 0, 32'h200);
        check_log("a_after_redirect1", 1, 32'h204);

        // ---- A: random traffic with redirects ----
        run_random(1500, 4);

        // ---- A: reset mid-stream with 2 outstanding ----
        resp_en = 1'b0; gnt = 1'b1; ready = 1'b1; redir = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2) found = 1'b1;
            else step();
        end
        check("a_two_outstanding_reached", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midreset", PC_A);
        do_reset(1'b0, PC_A);
        gnt = 1'b1; ready = 1'b1;
        run(12);
        check_log("a_restart0", 0, 32'h0);
        check_log("a_restart1", 1, 32'h4);

        // ---- B: PC wrap and full-rate streaming ----
        do_reset(1'b1, PC_B);
        gnt = 1'b1; ready = 1'b1;
        run(12);
        check("b_first_valid_cycle", 32'(first_valid), 32'd2);
        check("b_continuous_valid", 32'(n_valid), 32'd10);
        check_log("b_wrap0", 0, 32'hFFFF_FFF8);
        check_log("b_wrap1", 1, 32'hFFFF_FFFC);
        check_log("b_wrap2", 2, 32'h0000_0000);
        check_log("b_wrap3", 3, 32'h0000_0004);

        // ---- B: redirect with 2 in flight and 1 buffered ----
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2 && sb_q.size() == 1) begin
                redir = 1'b1; redir_pc = 32'h0000_0103;
                ready = 1'b1; resp_en = 1'b1;
                pop_log.delete();
                step();
                found = 1'b1;
            end else begin
                ready = 1'b0; resp_en = 1'b0;
                step();
            end
        end
        check("b_redirect_state_reached", 32'(found), 32'd1);
        ready = 1'b1; resp_en = 1'b1;
        run(12);
        check_log("b_after_redirect0", 0, 32'h100);
        check_log("b_after_redirect1", 1, 32'h104);

        // ---- B: random traffic with redirects ----
        run_random(1000, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
